mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 140 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - RV32M multi-cycle multiply/divide sequencer; MDU_DIV_EN enables division
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state, state_next;
    logic [4:0]        cnt;
    logic [1:0]        fn;
    logic              neg_res;
    logic [XLEN-1:0]   a_mag;
    logic [2*XLEN-1:0] acc, step_next, prod_fix;
    logic              accept, fast, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs, fast_val, mul_val, fix_val;
    logic [XLEN:0]     mul_sum;
`ifdef MDU_DIV_EN
    logic              is_div, div_zero, div_ovf;
    logic [XLEN-1:0]   b_mag, div_raw, div_val;
    logic [XLEN+1:0]   div_r, div_diff;
`endif

    assign accept = start && !kill && (state == S_IDLE);
    assign stall  = accept || (state == S_CALC) || (state == S_FIX);

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed & op_a[XLEN-1];
    assign b_neg = b_signed & op_b[XLEN-1];
    assign a_abs = a_neg ? -op_a : op_a;
    assign b_abs = b_neg ? -op_b : op_b;

    // Multiplier sits in the low half of acc and is consumed LSB-first as the product shifts in.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    assign prod_fix = neg_res ? -acc : acc;
    assign mul_val  = (fn == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_val = div_zero ? (funct3[1] ? op_a : '1)
                               : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // Restoring step: remainder in the high half, dividend shifts out while quotient bits shift in.
    assign div_r     = {1'b0, acc[2*XLEN-1:XLEN-1]};
    assign div_diff  = div_r - {2'b00, b_mag};
    assign step_next = !is_div ? {mul_sum, acc[XLEN-1:1]}
                     : div_diff[XLEN+1] ? {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                        : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign div_raw   = fn[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    assign div_val   = neg_res ? -div_raw : div_raw;
    assign fix_val   = is_div ? div_val : mul_val;
`else
    assign fast      = funct3[2];
    assign fast_val  = '0;
    assign step_next = {mul_sum, acc[XLEN-1:1]};
    assign fix_val   = mul_val;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = fast ? S_DONE : S_CALC;
            S_CALC:  if (kill) state_next = S_IDLE;
                     else if (cnt == 5'd31) state_next = S_FIX;
            S_FIX:   state_next = kill ? S_IDLE : S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            acc     <= '0;
            a_mag   <= '0;
            fn      <= '0;
            neg_res <= 1'b0;
`ifdef MDU_DIV_EN
            b_mag   <= '0;
            is_div  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_DONE);
            case (state)
                S_IDLE: if (accept) begin
                    fn      <= funct3[1:0];
                    neg_res <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    a_mag   <= a_abs;
                    cnt     <= '0;
`ifdef MDU_DIV_EN
                    is_div  <= funct3[2];
                    b_mag   <= b_abs;
                    acc     <= {{XLEN{1'b0}}, funct3[2] ? a_abs : b_abs};
`else
                    acc     <= {{XLEN{1'b0}}, b_abs};
`endif
                    if (fast) result <= fast_val;
                end
                S_CALC: if (!kill) begin
                    acc <= step_next;
                    cnt <= cnt + 5'd1;
                end
                S_FIX: if (!kill) result <= fix_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - randomized self-checking bench for mdu_sequencer against an arithmetic model
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_result;

    always #5 clk = ~clk;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_val(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'b000: p = ua * ub;
            3'b001: p = sa * sb;
            3'b010: p = sa * ub;
            3'b011: p = ua * ub;
            default: p = '0;
        endcase
        if (!f[2]) return (f == 3'b000) ? p[31:0] : p[63:32];
`ifdef MDU_DIV_EN
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
        case (f)
            3'b100: p = sa / sb;
            3'b101: p = ua / ub;
            3'b110: p = sa % sb;
            default: p = ua % ub;
        endcase
        return p[31:0];
`else
        return 32'h0;
`endif
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 34;
`ifdef MDU_DIV_EN
        if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 34;
`else
        return 1;
`endif
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int kill_at, input bit hold);
        int          lat, ndone, exp_lat;
        bit          stall_ok, exp_stall;
        logic [31:0] exp_res;
        exp_lat = model_lat(f, a, b);
        exp_res = model_val(f, a, b);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1; kill = 1'b0;
        #1 stall_ok = (stall === 1'b1);
        lat = 0;
        ndone = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_stall = (kill_at > 0) ? (n <= kill_at) : (n < exp_lat);
            if (stall !== exp_stall) stall_ok = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            kill = (n == kill_at);
            if (!hold || kill || ndone > 0) start = 1'b0;
        end
        kill = 1'b0;
        check_eq($sformatf("f%0d_stall", f), stall_ok, 1);
        check_eq($sformatf("f%0d_busy_end", f), busy, 0);
        if (kill_at > 0) begin
            check_eq($sformatf("f%0d_kill_ndone", f), ndone, 0);
            check_eq($sformatf("f%0d_kill_result", f), result, model_result);
        end else begin
            check_eq($sformatf("f%0d_latency", f), lat, exp_lat);
            check_eq($sformatf("f%0d_ndone", f), ndone, 1);
            check_eq($sformatf("f%0d_a%0h_b%0h_result", f, a, b), result, exp_res);
            model_result = exp_res;
        end
    endtask

    initial begin
        int          ndone;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          k;
        reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_stall", stall, 0);
        reset = 1'b0;
        model_result = '0;

        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, -1, 1'b0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        do_op(3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 1'b0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        do_op(3'b101, 32'd5, 32'd0, -1, 1'b0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        do_op(3'b111, 32'd9, 32'd4, -1, 1'b0);
        do_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 11, 1'b1);
        do_op(3'b011, 32'hDEAD_BEEF, 32'h0000_1001, -1, 1'b1);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check_eq("rst_start_busy", busy, 0);
        check_eq("rst_start_result", result, 0);
        model_result = '0;
        @(negedge clk);
        check_eq("rst_start_busy2", busy, 0);

        // reset mid-operation discards the op
        do_op(3'b000, 32'd6, 32'd7, -1, 1'b0);
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_result", result, 0);
        model_result = '0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check_eq("midrst_nodone", ndone, 0);

        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            k = ($urandom_range(0, 4) == 0 && model_lat(f, a, b) == 34) ? int'($urandom_range(1, 33)) : -1;
            do_op(f, a, b, k, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
